serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 15 +
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and sizing helpers for the serial arithmetic cores
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-bit serial core; never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result buses
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );

endinterface

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit difference and borrow of x - y
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d0;
    logic             w_bo0;
    logic             w_di;
    logic             w_bo1;
    logic             w_borrow_next;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_work_next;

    // Full subtractor: first stage subtracts b from a, second subtracts the incoming borrow
    half_subtractor u_hs0 (.x(r_a[0]), .y(r_b[0]),   .d(w_d0), .bo(w_bo0));
    half_subtractor u_hs1 (.x(w_d0),   .y(r_borrow), .d(w_di), .bo(w_bo1));

    assign w_borrow_next = w_bo0 | w_bo1;

    // New difference bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign w_ext       = {w_di, r_work};
    assign w_work_next = w_ext[WIDTH:1];

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_bout;

    // Control FSM with datapath; results are committed only on the final SHIFT edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= SHIFT;
                        r_busy   <= 1'b1;
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_work   <= '0;
                    end
                end
                SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + CW'(1);
                    r_work   <= w_work_next;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_diff  <= w_work_next;
                        r_bout  <= w_borrow_next;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor at WIDTH 8, 13 and 1
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(13)) if13 ();
    serial_subtractor_if #(.WIDTH(1))  if1 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13.slave));
    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

    function automatic logic [7:0] fa(input int c);
        return 8'(c * 37 + 11);
    endfunction

    function automatic logic [7:0] fb(input int c);
        return 8'(c * 53 + 200);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bc,
                        output logic [7:0] d, output logic bo, output logic tail);
        if8.a = a; if8.b = b; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a = ~a; if8.b = ~b;
        lat = 0; bc = 0;
        while (lat <= 30) begin
            if (if8.busy) bc++;
            if (if8.done) break;
            @(posedge clk); #1;
            lat++;
        end
        d = if8.diff; bo = if8.borrow_out;
        @(posedge clk); #1;
        tail = if8.busy | if8.done;
    endtask

    task automatic run13(input logic [12:0] a, input logic [12:0] b, output int lat,
                         output logic [12:0] d, output logic bo, output logic tail);
        if13.a = a; if13.b = b; if13.start = 1'b1;
        @(posedge clk); #1;
        if13.start = 1'b0; if13.a = ~a; if13.b = ~b;
        lat = 0;
        while (lat <= 40 && !if13.done) begin
            @(posedge clk); #1;
            lat++;
        end
        d = if13.diff; bo = if13.borrow_out;
        @(posedge clk); #1;
        tail = if13.busy | if13.done;
    endtask

    task automatic run1(input logic a, input logic b, output int lat,
                        output logic d, output logic bo, output logic tail);
        if1.a = a; if1.b = b; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0; if1.a = ~a; if1.b = ~b;
        lat = 0;
        while (lat <= 10 && !if1.done) begin
            @(posedge clk); #1;
            lat++;
        end
        d = if1.diff; bo = if1.borrow_out;
        @(posedge clk); #1;
        tail = if1.busy | if1.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.diff, if8.borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b want all 0",
                     if8.busy, if8.done, if8.diff, if8.borrow_out);
        end
        checks++;
        if ({if1.busy, if1.done, if1.diff, if1.borrow_out} !== 4'd0) begin
            errors++;
            $display("FAIL reset1: got busy=%b done=%b diff=%b bo=%b want all 0",
                     if1.busy, if1.done, if1.diff, if1.borrow_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [7:0] d;
        logic bo, tail;
        run8(8'h5A, 8'h3C, lat, bc, d, bo, tail);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", bc); end
        checks++;
        if (d !== 8'h1E) begin errors++; $display("FAIL basic_diff: got %h want 1e", d); end
        checks++;
        if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", bo); end
        checks++;
        if (tail !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: busy|done after DONE got %b want 0", tail); end
    endtask

    task automatic test_boundary();
        int lat, bc;
        logic [7:0] d;
        logic bo, tail;
        run8(8'h00, 8'h01, lat, bc, d, bo, tail);
        checks++;
        if (d !== 8'hFF || bo !== 1'b1)
            begin errors++; $display("FAIL underflow: got diff=%h bo=%b want ff 1", d, bo); end
        run8(8'h80, 8'h80, lat, bc, d, bo, tail);
        checks++;
        if (d !== 8'h00 || bo !== 1'b0)
            begin errors++; $display("FAIL equal: got diff=%h bo=%b want 00 0", d, bo); end
        run8(8'hFF, 8'h00, lat, bc, d, bo, tail);
        checks++;
        if (d !== 8'hFF || bo !== 1'b0)
            begin errors++; $display("FAIL max_minus_zero: got diff=%h bo=%b want ff 0", d, bo); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        logic [7:0] ea, eb;
        int w;
        for (int c = 0; c <= 40; c++) begin
            if8.a = fa(c); if8.b = fb(c); if8.start = 1'b1;
            @(posedge clk); #1;
            exp_done = (c >= 8) && ((c - 8) % 10 == 0);
            checks++;
            if (if8.done !== exp_done)
                begin errors++; $display("FAIL b2b_done c=%0d: got %b want %b", c, if8.done, exp_done); end
            if (exp_done) begin
                ea = fa(c - 8); eb = fb(c - 8);
                checks++;
                if (if8.diff !== 8'(ea - eb) || if8.borrow_out !== (ea < eb))
                    begin
                        errors++;
                        $display("FAIL b2b_result c=%0d: got diff=%h bo=%b want %h %b",
                                 c, if8.diff, if8.borrow_out, 8'(ea - eb), ea < eb);
                    end
            end
        end
        if8.start = 1'b0;
        w = 0;
        while (if8.busy && w < 30) begin @(posedge clk); #1; w++; end
        checks++;
        if (if8.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy got %b want 0", if8.busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic [7:0] d;
        logic bo, tail;
        if8.a = 8'h33; if8.b = 8'h11; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({if8.busy, if8.done, if8.diff, if8.borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bo=%b want all 0",
                     if8.busy, if8.done, if8.diff, if8.borrow_out);
        end
        if8.a = 8'h44; if8.b = 8'h01; if8.start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start: busy got %b want 0", if8.busy); end
        rst = 1'b0; if8.start = 1'b0;
        @(posedge clk); #1;
        run8(8'h10, 8'h20, lat, bc, d, bo, tail);
        checks++;
        if (d !== 8'hF0 || bo !== 1'b1 || lat !== 8)
            begin errors++; $display("FAIL after_reset: got diff=%h bo=%b lat=%0d want f0 1 8", d, bo, lat); end
    endtask

    task automatic test_width1();
        int lat;
        logic d, bo, tail;
        run1(1'b1, 1'b0, lat, d, bo, tail);
        checks++;
        if (d !== 1'b1 || bo !== 1'b0 || lat !== 1 || tail !== 1'b0)
            begin errors++; $display("FAIL w1_10: got d=%b bo=%b lat=%0d tail=%b want 1 0 1 0", d, bo, lat, tail); end
        run1(1'b0, 1'b1, lat, d, bo, tail);
        checks++;
        if (d !== 1'b1 || bo !== 1'b1 || lat !== 1)
            begin errors++; $display("FAIL w1_01: got d=%b bo=%b lat=%0d want 1 1 1", d, bo, lat); end
        run1(1'b1, 1'b1, lat, d, bo, tail);
        checks++;
        if (d !== 1'b0 || bo !== 1'b0)
            begin errors++; $display("FAIL w1_11: got d=%b bo=%b want 0 0", d, bo); end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [7:0] a8, b8, d8;
        logic [12:0] a13, b13, d13;
        logic bo, tail;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            run8(a8, b8, lat, bc, d8, bo, tail);
            checks++;
            if (d8 !== 8'(a8 - b8) || bo !== (a8 < b8) || lat !== 8) begin
                errors++;
                $display("FAIL rand8 %h-%h: got diff=%h bo=%b lat=%0d want %h %b 8",
                         a8, b8, d8, bo, lat, 8'(a8 - b8), a8 < b8);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            a13 = 13'($urandom); b13 = 13'($urandom);
            run13(a13, b13, lat, d13, bo, tail);
            checks++;
            if (d13 !== 13'(a13 - b13) || bo !== (a13 < b13) || lat !== 13) begin
                errors++;
                $display("FAIL rand13 %h-%h: got diff=%h bo=%b lat=%0d want %h %b 13",
                         a13, b13, d13, bo, lat, 13'(a13 - b13), a13 < b13);
            end
        end
    endtask

    initial begin
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
        if13.start = 1'b0; if13.a = '0; if13.b = '0;
        if1.start = 1'b0;  if1.a = '0;  if1.b = '0;
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
